// File: rtl/register_file.sv
// register_file: MIPS 2-read/1-write register file with hardwired $0 and optional write-through bypass
module register_file #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 32,
   parameter int AW     = 5,
   parameter int BYPASS = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [AW-1:0]    read_reg1,
   input  logic [AW-1:0]    read_reg2,
   input  logic [AW-1:0]    write_reg,
   input  logic [WIDTH-1:0] write_data,
   input  logic             reg_write,
   output logic [WIDTH-1:0] read_data1,
   output logic [WIDTH-1:0] read_data2
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_wr;
   logic             w_byp1;
   logic             w_byp2;
   always_ff @(posedge clk)
      if (reset)
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      else if (w_wr)
         r_mem[write_reg] <= write_data;
   always_comb begin
      w_wr       = reg_write && (write_reg != '0);
      w_byp1     = (BYPASS != 0) && w_wr && !reset && (read_reg1 == write_reg);
      w_byp2     = (BYPASS != 0) && w_wr && !reset && (read_reg2 == write_reg);
      read_data1 = (read_reg1 == '0) ? '0 : (w_byp1 ? write_data : r_mem[read_reg1]);
      read_data2 = (read_reg2 == '0) ? '0 : (w_byp2 ? write_data : r_mem[read_reg2]);
   end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: random and directed checks of register_file (BYPASS=0 and 1) against an array model
module tb_register_file;
   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic [4:0]  r1;
   logic [4:0]  r2;
   logic [31:0] q0_1, q0_2, q1_1, q1_2;
   logic [31:0] model [32];
   bit          started = 1'b0;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   register_file #(.WIDTH(32), .DEPTH(32), .AW(5), .BYPASS(0)) u_nb (
      .clk(clk), .reset(rst), .read_reg1(r1), .read_reg2(r2), .write_reg(wa),
      .write_data(wd), .reg_write(we), .read_data1(q0_1), .read_data2(q0_2));
   register_file #(.WIDTH(32), .DEPTH(32), .AW(5), .BYPASS(1)) u_byp (
      .clk(clk), .reset(rst), .read_reg1(r1), .read_reg2(r2), .write_reg(wa),
      .write_data(wd), .reg_write(we), .read_data1(q1_1), .read_data2(q1_2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (byp && !rst && we && wa != 0 && wa == a) return wd;
      return model[a];
   endfunction

   // model state follows the architectural rule: reset wins, $0 never stored
   always @(posedge clk) begin
      if (rst) begin
         foreach (model[i]) model[i] = 32'h0;
         started = 1'b1;
      end else if (we && wa != 0) model[wa] = wd;
   end

   always @(negedge clk) if (started) begin
      chk("m_nb_rd1", q0_1, exp_rd(1'b0, r1));
      chk("m_nb_rd2", q0_2, exp_rd(1'b0, r2));
      chk("m_by_rd1", q1_1, exp_rd(1'b1, r1));
      chk("m_by_rd2", q1_2, exp_rd(1'b1, r2));
   end

   task automatic edge1;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      we = 1'b1; wa = a; wd = d;
      edge1();
      we = 1'b0;
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; wa = '0; wd = '0; r1 = '0; r2 = '0;
      edge1();
      rst = 1'b0;
      for (int a = 0; a < 32; a++) begin
         r1 = 5'(a); r2 = 5'(31 - a);
         #0.1;
         chk("rst_sweep_nb1", q0_1, 32'h0);
         chk("rst_sweep_nb2", q0_2, 32'h0);
         chk("rst_sweep_by1", q1_1, 32'h0);
         chk("rst_sweep_by2", q1_2, 32'h0);
      end
      wr(5'd8, 32'hDEADBEEF);
      wr(5'd9, 32'h00000005);
      wr(5'd12, 32'h00000077);
      r1 = 5'd8; r2 = 5'd9; #1;
      chk("wr_r8", q0_1, 32'hDEADBEEF);
      chk("wr_r9", q0_2, 32'h00000005);
      chk("wr_r8_byp", q1_1, 32'hDEADBEEF);
      we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; r1 = 5'd0; #1;
      chk("zero_pre_nb", q0_1, 32'h0);
      chk("zero_pre_byp", q1_1, 32'h0);
      edge1();
      we = 1'b0; #1;
      chk("zero_post_nb", q0_1, 32'h0);
      chk("zero_post_byp", q1_1, 32'h0);
      we = 1'b0; wa = 5'd8; wd = 32'h1;
      edge1();
      r1 = 5'd8; #1;
      chk("we_off_r8", q0_1, 32'hDEADBEEF);
      chk("we_off_r8_byp", q1_1, 32'hDEADBEEF);
      wr(5'd10, 32'h0000000A);
      we = 1'b1; wa = 5'd10; wd = 32'h00000055; r1 = 5'd10; r2 = 5'd10; #1;
      chk("same_nb1", q0_1, 32'h0000000A);
      chk("same_nb2", q0_2, 32'h0000000A);
      chk("same_byp1", q1_1, 32'h00000055);
      chk("same_byp2", q1_2, 32'h00000055);
      edge1();
      we = 1'b0; #1;
      chk("after_nb", q0_1, 32'h00000055);
      chk("after_byp", q1_2, 32'h00000055);
      rst = 1'b1; we = 1'b1; wa = 5'd12; wd = 32'h1234; r1 = 5'd12; r2 = 5'd8; #1;
      chk("rst_nobyp_r12", q1_1, 32'h00000077);
      chk("rst_old_r8", q0_2, 32'hDEADBEEF);
      edge1();
      rst = 1'b0; we = 1'b0; #1;
      chk("rst_win_r12", q0_1, 32'h0);
      chk("rst_win_r12_byp", q1_1, 32'h0);
      chk("rst_clr_r8", q0_2, 32'h0);
      r1 = 5'd9; r2 = 5'd10; #1;
      chk("rst_clr_r9", q0_1, 32'h0);
      chk("rst_clr_r10", q1_2, 32'h0);
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 99) == 0);
         we  = ($urandom_range(0, 3) != 0);
         wa  = 5'($urandom_range(0, 31));
         wd  = $urandom;
         r1  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         r2  = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? r1 : wa) : 5'($urandom_range(0, 31));
         edge1();
      end
      rst = 1'b0; we = 1'b0;
      edge1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
